// File: rtl/i_cache.sv
// Direct-mapped, read-only instruction cache with 4-word lines.
// Hits return the word combinationally; misses fill a whole line from the shared bus.
module i_cache #(
  parameter int INDEX_BITS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_mem_read,
  input  logic [15:0] i_address,
  input  logic        bus_granted,
  input  logic        mem_ready,
  input  logic [63:0] mem_data,
  output logic        i_ready,
  output logic [15:0] i_data,
  output logic        mem_read,
  output logic [15:0] mem_addr,
  output logic [15:0] num_hit,
  output logic [15:0] num_miss
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 14 - INDEX_BITS;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t               state_reg;
  logic [LINES-1:0]     valid_reg;
  logic [TAG_BITS-1:0]  tag_mem [LINES];
  logic [63:0]          data_mem [LINES];
  logic [15:0]          mem_addr_reg;
  logic [15:0]          num_hit_reg;
  logic [15:0]          num_miss_reg;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic [15:0]           line_words [4];
  logic                  hit;
  logic                  start_fill;
  logic                  fill_done;

  assign offset     = i_address[1:0];
  assign index      = i_address[INDEX_BITS+1:2];
  assign tag        = i_address[15:INDEX_BITS+2];
  assign fill_index = mem_addr_reg[INDEX_BITS+1:2];
  assign fill_tag   = mem_addr_reg[15:INDEX_BITS+2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign line_words[gi] = data_mem[index][16*gi +: 16];
    end
  endgenerate

  assign hit        = i_mem_read && valid_reg[index] && (tag_mem[index] == tag) && (state_reg == IDLE);
  assign start_fill = i_mem_read && !hit && !bus_granted && (state_reg == IDLE);
  assign fill_done  = (state_reg == MEM_WAIT) && mem_ready;

  assign i_ready  = hit;
  assign i_data   = hit ? line_words[offset] : 16'h0000;
  assign mem_read = (state_reg == MEM_WAIT);
  assign mem_addr = mem_addr_reg;
  assign num_hit  = num_hit_reg;
  assign num_miss = num_miss_reg;

  // Reset drops state straight to IDLE, so an outstanding fill is abandoned at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      valid_reg    <= '0;
      mem_addr_reg <= 16'h0000;
      num_hit_reg  <= 16'h0000;
      num_miss_reg <= 16'h0000;
    end else begin
      if (hit && (num_hit_reg != 16'hFFFF))
        num_hit_reg <= num_hit_reg + 16'd1;
      case (state_reg)
        IDLE: begin
          if (start_fill) begin
            mem_addr_reg <= {i_address[15:2], 2'b00};
            if (num_miss_reg != 16'hFFFF)
              num_miss_reg <= num_miss_reg + 16'd1;
            state_reg <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            valid_reg[fill_index] <= 1'b1;
            state_reg             <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= mem_data;
    end
  end

endmodule
